// File: rtl/uart_frame_rx_if.sv
// Signal bundle between the UART frame receiver and the consumer of its frames.
// The slave side is the receiver; the master side drives the line and the acknowledge.
`timescale 1ns/1ps
interface uart_frame_rx_if #(
  parameter int DATA_W = 320
);
  logic              rx;
  logic              recv_ack;
  logic              recv;
  logic [DATA_W-1:0] data;
  logic [3:0]        sta;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rx, recv_ack,
    input  recv, data, sta, frame_err, overrun
  );

  modport slave (
    input  rx, recv_ack,
    output recv, data, sta, frame_err, overrun
  );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that assembles FRAME_BYTES bytes into one wide word.
// A complete frame is published on data with a level recv flag held until acknowledged.
// Partial frames are dropped on a bad stop bit, on a long idle gap, or by reset.
`timescale 1ns/1ps
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BYTES  = 40,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_rx_if.slave bus
);

  localparam int DATA_W   = 8 * FRAME_BYTES;
  localparam int BIT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int BYTE_W   = $clog2(FRAME_BYTES + 1);

  // Down-counter reload values: the sample happens when the counter reaches zero.
  localparam logic [BIT_W-1:0]  HALF_LOAD = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  FULL_LOAD = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta, rxs;
  logic [BIT_W-1:0]    bit_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   data_q;
  logic                frame_done;
  logic                recv_q;
  logic                frame_err_q;
  logic                overrun_q;
  logic                tick;
  logic                byte_ok;
  logic                byte_bad;
  logic                idle_wait;
  logic                timeout_hit;

  assign tick        = (bit_cnt == '0);
  assign idle_wait   = (state_q == IDLE) && rxs && (byte_cnt != '0);
  assign timeout_hit = idle_wait && (to_cnt == TO_LAST);

  // Two-flop synchronizer; the line idles high so reset to 1 avoids a false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rxs take the old rx_meta, forming two real flops.
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Bit-FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and byte accept/reject strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held (no latch).
    state_d  = state_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state_q)
      IDLE:  if (!rxs) state_d = START;
      START: if (tick) state_d = rxs ? IDLE : DATA;
      DATA:  if (tick && (bit_idx == 3'd7)) state_d = STOP;
      STOP: begin
        if (tick) begin
          state_d  = IDLE;
          byte_ok  = rxs;
          byte_bad = !rxs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt <= HALF_LOAD;
          bit_idx <= '0;
        end
        START: begin
          bit_cnt <= tick ? FULL_LOAD : bit_cnt - 1'b1;
          bit_idx <= '0;
        end
        DATA: begin
          if (tick) begin
            bit_cnt <= FULL_LOAD;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: bit_cnt <= tick ? HALF_LOAD : bit_cnt - 1'b1;
      endcase
    end
  end

  // Frame assembly, byte count, idle timeout and frame-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the wide assembly register is reset too, so no partial frame survives reset.
      asm_q       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      frame_done  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_err_q <= 1'b0;
      if (byte_ok) begin
        asm_q <= DATA_W'({asm_q, shreg});
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt   <= '0;
          frame_done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (byte_bad) begin
        frame_err_q <= 1'b1;
        byte_cnt    <= '0;
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end

      if (idle_wait && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                           to_cnt <= '0;
    end
  end

  // Frame hand-off: publish on recv rise, or flag overrun if the consumer is still busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      recv_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!recv_q || bus.recv_ack) begin
          data_q <= asm_q;
          recv_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (bus.recv_ack) begin
        recv_q <= 1'b0;
      end
    end
  end

  assign bus.recv      = recv_q;
  assign bus.data      = data_q;
  assign bus.sta       = {2'b00, state_q};
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: full frames, glitch rejection, framing error,
// overrun, idle timeout and mid-frame reset, at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_frame_rx;
  localparam int CPB = 16;
  localparam int NB  = 40;
  localparam int TOB = 20;
  localparam int DW  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   fe_base;
  int   ov_base;
  logic [DW-1:0] exp_frame;
  logic [DW-1:0] frame1;

  always #5 clk = ~clk;

  uart_frame_rx_if #(.DATA_W(DW)) bus ();

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (NB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(CPB);
    end
    bus.rx = stop_bit;
    idle(CPB);
    bus.rx = 1'b1;
  endtask

  task automatic send_ramp(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
  endtask

  function automatic logic [DW-1:0] ramp(input logic [7:0] base);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r = {r[DW-9:0], base + 8'(i)};
    return r;
  endfunction

  task automatic ack_pulse(input string tag);
    bus.recv_ack = 1'b1;
    idle(1);
    check(tag, DW'(bus.recv), DW'(0));
    bus.recv_ack = 1'b0;
    idle(1);
  endtask

  initial begin
    rst          = 1'b0;
    bus.rx       = 1'b1;
    bus.recv_ack = 1'b0;
    idle(3);
    check("rst_recv",  DW'(bus.recv), DW'(0));
    check("rst_data",  bus.data, '0);
    check("rst_sta",   DW'(bus.sta), DW'(0));
    check("rst_ferr",  DW'(bus.frame_err), DW'(0));
    check("rst_ovr",   DW'(bus.overrun), DW'(0));
    rst = 1'b1;
    idle(5);

    // Back-to-back ramp 0x00..0x27, no acknowledge.
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_ramp(8'h00, NB);
    idle(2);
    exp_frame = ramp(8'h00);
    check("ramp_recv",  DW'(bus.recv), DW'(1));
    check("ramp_data",  bus.data, exp_frame);
    check("ramp_first", DW'(bus.data[DW-1 -: 8]), DW'(8'h00));
    check("ramp_last",  DW'(bus.data[7:0]), DW'(8'h27));
    check("ramp_no_fe", DW'(fe_cnt - fe_base), DW'(0));
    check("ramp_no_ov", DW'(ov_cnt - ov_base), DW'(0));
    ack_pulse("ramp_ack");

    // Short low glitch on the idle line must not start a byte.
    bus.rx = 1'b0;
    idle(4);
    check("glitch_start", DW'(bus.sta), DW'(1));
    idle(2);
    bus.rx = 1'b1;
    idle(20);
    check("glitch_idle", DW'(bus.sta), DW'(0));
    send_ramp(8'h40, NB);
    idle(2);
    check("glitch_recv", DW'(bus.recv), DW'(1));
    check("glitch_data", bus.data, ramp(8'h40));
    ack_pulse("glitch_ack");

    // Fifth byte with a bad stop bit, then a fresh 40-byte frame.
    fe_base = fe_cnt;
    send_ramp(8'h10, 4);
    send_byte(8'h14, 1'b0);
    bus.rx = 1'b1;
    idle(2 * CPB);
    check("ferr_pulse", DW'(fe_cnt - fe_base), DW'(1));
    check("ferr_recv",  DW'(bus.recv), DW'(0));
    send_ramp(8'h80, NB - 1);
    idle(2);
    check("ferr_no_early", DW'(bus.recv), DW'(0));
    send_byte(8'h80 + 8'(NB - 1), 1'b1);
    idle(2);
    frame1 = ramp(8'h80);
    check("ferr_recv_set", DW'(bus.recv), DW'(1));
    check("ferr_data",     bus.data, frame1);
    check("ferr_single",   DW'(fe_cnt - fe_base), DW'(1));

    // Second frame while the first is unacknowledged.
    ov_base = ov_cnt;
    send_ramp(8'hC0, NB);
    idle(2);
    check("ovr_pulse", DW'(ov_cnt - ov_base), DW'(1));
    check("ovr_recv",  DW'(bus.recv), DW'(1));
    check("ovr_data",  bus.data, frame1);
    ack_pulse("ovr_ack");

    // Ten bytes, long idle gap, then 40 x 0xA5.
    fe_base = fe_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'h11, 1'b1);
    idle(340);
    check("to_recv", DW'(bus.recv), DW'(0));
    for (int i = 0; i < NB; i++) send_byte(8'hA5, 1'b1);
    idle(2);
    exp_frame = {NB{8'hA5}};
    check("to_recv_set", DW'(bus.recv), DW'(1));
    check("to_data",     bus.data, exp_frame);
    check("to_no_fe",    DW'(fe_cnt - fe_base), DW'(0));
    ack_pulse("to_ack");

    // Reset in the middle of byte 20.
    send_ramp(8'h55, 19);
    bus.rx = 1'b0;
    idle(CPB);
    bus.rx = 1'b1;
    idle(24);
    check("mid_sta", DW'(bus.sta), DW'(2));
    rst = 1'b0;
    idle(2);
    check("mrst_recv", DW'(bus.recv), DW'(0));
    check("mrst_data", bus.data, '0);
    check("mrst_sta",  DW'(bus.sta), DW'(0));
    check("mrst_ferr", DW'(bus.frame_err), DW'(0));
    check("mrst_ovr",  DW'(bus.overrun), DW'(0));
    bus.rx = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(5);
    send_ramp(8'h30, NB);
    idle(2);
    check("post_recv", DW'(bus.recv), DW'(1));
    check("post_data", bus.data, ramp(8'h30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 8..4095.
REQ-002 Parameter FRAME_BYTES, default 40, bytes per frame; data width = 8*FRAME_BYTES = 320.
REQ-003 Parameter TIMEOUT_BITS, default 20, idle bit-times that abort a partial frame.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rx  in  1  asynchronous UART serial line; idles high; 8N1, LSB first.
REQ-007 recv_ack  in  1  consumer acknowledge for the current frame.
REQ-008 recv  out  1  frame-ready flag, level, held until acknowledged.
REQ-009 data  out  320  last completed frame; first received byte in data[319:312].
REQ-010 sta  out  4  bit-FSM state: 0 IDLE, 1 START, 2 DATA, 3 STOP; 4..15 unused.
REQ-011 frame_err  out  1  one-cycle pulse on a bad stop bit.
REQ-012 overrun  out  1  one-cycle pulse when a frame completes while recv=1.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 IDLE: rxs=0 SHALL move to START and load the bit counter so that the sample falls at CLKS_PER_BIT/2 (integer division).
REQ-015 START: at mid-bit, rxs=1 SHALL be treated as a glitch, returning to IDLE with no byte and no error; rxs=0 SHALL move to DATA.
REQ-016 DATA: bits SHALL be sampled every CLKS_PER_BIT cycles after the start mid-point, 8 samples, LSB first; after the 8th sample the FSM SHALL move to STOP.
REQ-017 STOP: the sample SHALL occur CLKS_PER_BIT after the last data sample; rxs=1 accepts the byte; rxs=0 discards it, pulses frame_err, and clears the byte count.
REQ-018 After STOP the FSM SHALL return to IDLE on the sample cycle, so back-to-back bytes with zero idle time are received.
REQ-019 Each accepted byte SHALL be shifted into a 320-bit assembly register: asm <= {asm[311:0], byte}; byte count increments.
REQ-020 On acceptance of byte FRAME_BYTES, the byte count SHALL clear to 0, and the following register update SHALL occur on the next cycle:
- recv=0: data <= assembled word and recv <= 1.
- recv=1: data is left unchanged, overrun pulses, and the frame is dropped.
REQ-021 recv SHALL clear on the cycle after recv_ack is sampled high; recv_ack while recv=0 SHALL be ignored.
REQ-022 If a frame completes in the same cycle that recv_ack clears recv, the new frame SHALL be loaded (recv stays 1, no overrun).
REQ-023 While IDLE with byte count>0, a counter SHALL count idle cycles; reaching TIMEOUT_BITS*CLKS_PER_BIT SHALL clear the byte count without error; any start bit clears the counter.
REQ-024 data SHALL only change when recv rises; partial frames are never visible on data.
REQ-025 sta SHALL reflect the registered FSM state with no combinational path from rx.

Reset
REQ-026 With rst=0, the following SHALL hold:
- Synchronizer flops = 1.
- FSM = IDLE (sta=0).
- recv=0, data=0, frame_err=0, overrun=0.
- Byte, bit and timeout counters = 0.
REQ-027 Reset asserted mid-byte or mid-frame SHALL discard all partial data.
REQ-028 After release, the first valid start edge SHALL begin reception normally.

Verification (bench CLKS_PER_BIT=16, TIMEOUT_BITS=20)
REQ-029 40 bytes 0x00..0x27, back-to-back, recv_ack tied 0 -> recv=1, data[319:312]=0x00, data[7:0]=0x27, no error pulses.
REQ-030 Apply a 6-cycle low glitch on idle rx -> sta returns to 0, no byte counted; then a full 40-byte frame -> correct data.
REQ-031 Byte 5 sent with stop bit=0 -> one frame_err pulse; the next 40 good bytes form the frame; no early recv.
REQ-032 First frame unacked, second 40-byte frame sent -> one overrun pulse, data still holds frame 1; pulse recv_ack -> recv=0 the next cycle.
REQ-033 10 bytes, then idle 320+ cycles, then 40 bytes 0xA5 -> data = 320 bits of repeated 0xA5.
REQ-034 Assert rst during byte 20 -> all outputs 0; a following full frame is received correctly.
